// File: rtl/ram_waitstate.sv
// Single-port synchronous RAM with byte strobes, req/ready handshake,
// programmable wait states, registered read data and optional clear-after-reset.
module ram_waitstate #(
    parameter int AWIDTH         = 10,
    parameter int DWIDTH         = 32,
    parameter int WAIT_STATES    = 0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                mem_en,
    input  logic                mem_wr,
    input  logic [DWIDTH/8-1:0] mem_be,
    input  logic [31:0]         addr,
    input  logic [DWIDTH-1:0]   data_wr,
    output logic [DWIDTH-1:0]   data_rd,
    output logic                mem_ready,
    output logic                init_done
);

    localparam int NB    = DWIDTH / 8;
    localparam int OFS   = $clog2(NB);
    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic [DWIDTH-1:0]   data_rd_q, data_rd_d;
    logic                mem_ready_q, mem_ready_d;
    logic                init_done_q, init_done_d;
    logic [AWIDTH-1:0]   idx_q, idx_d;
    logic                wr_q, wr_d;
    logic [NB-1:0]       be_q, be_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;

    logic [DWIDTH-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [AWIDTH-1:0]   mem_widx;
    logic [DWIDTH-1:0]   mem_wdata;

    logic [AWIDTH-1:0]   acc_idx;
    logic                acc_wr;
    logic [NB-1:0]       acc_be;
    logic [DWIDTH-1:0]   acc_wdata;
    logic                acc_go;
    logic                addr_unused;

    assign addr_unused = ^addr;

    // With zero wait states the access happens on the accepting edge, so use live inputs.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_idx   = addr[AWIDTH+OFS-1 -: AWIDTH];
            acc_wr    = mem_wr;
            acc_be    = mem_be;
            acc_wdata = data_wr;
        end else begin
            acc_idx   = idx_q;
            acc_wr    = wr_q;
            acc_be    = be_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        data_rd_d   = data_rd_q;
        mem_ready_d = 1'b0;
        init_done_d = init_done_q;
        idx_d       = idx_q;
        wr_d        = wr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        acc_go      = 1'b0;
        mem_we      = 1'b0;
        mem_widx    = acc_idx;
        mem_wdata   = mem_q[acc_idx];
        for (int unsigned k = 0; k < NB; k++) begin
            if (acc_be[k]) mem_wdata[8*k +: 8] = acc_wdata[8*k +: 8];
        end

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_widx  = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + AWIDTH'(1);
                if (clr_cnt_q == '1) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                init_done_d = 1'b1;
                if (mem_en) begin
                    idx_d   = acc_idx;
                    wr_d    = mem_wr;
                    be_d    = mem_be;
                    wdata_d = data_wr;
                    if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        acc_go = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) acc_go = 1'b1;
                else                    wait_cnt_d = wait_cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (acc_go) begin
            state_d     = ST_RESP;
            mem_ready_d = 1'b1;
            if (acc_wr) mem_we    = 1'b1;
            else        data_rd_d = mem_q[acc_idx];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            data_rd_q   <= '0;
            mem_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            idx_q       <= '0;
            wr_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            data_rd_q   <= data_rd_d;
            mem_ready_q <= mem_ready_d;
            init_done_q <= init_done_d;
            idx_q       <= idx_d;
            wr_q        <= wr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_widx] <= mem_wdata;
    end

    assign data_rd   = data_rd_q;
    assign mem_ready = mem_ready_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_ram_waitstate.sv
// Bench for ram_waitstate: two instances (0 and 3 wait states, 16 words) checked
// against a word-array reference model with directed and random accesses.
module tb_ram_waitstate;

    logic        clk;
    logic        rstn;
    logic        en   [2];
    logic        wr   [2];
    logic [3:0]  be   [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic [31:0] rd   [2];
    logic        rdy  [2];
    logic        done [2];

    int          total;
    int          bad;
    int          ws [2] = '{0, 3};
    logic [31:0] model [2][16];
    logic [31:0] last_rd [2];

    ram_waitstate #(.AWIDTH(4), .DWIDTH(32), .WAIT_STATES(0), .CLEAR_ON_RESET(1'b1)) dut0 (
        .clk(clk), .rstn(rstn), .mem_en(en[0]), .mem_wr(wr[0]), .mem_be(be[0]),
        .addr(addr[0]), .data_wr(wd[0]), .data_rd(rd[0]), .mem_ready(rdy[0]), .init_done(done[0])
    );

    ram_waitstate #(.AWIDTH(4), .DWIDTH(32), .WAIT_STATES(3), .CLEAR_ON_RESET(1'b1)) dut3 (
        .clk(clk), .rstn(rstn), .mem_en(en[1]), .mem_wr(wr[1]), .mem_be(be[1]),
        .addr(addr[1]), .data_wr(wd[1]), .data_rd(rd[1]), .mem_ready(rdy[1]), .init_done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            last_rd[d] = '0;
            for (int i = 0; i < 16; i++) model[d][i] = '0;
        end
    endtask

    // Called just after a rising edge with the DUT idle; returns just after a rising edge.
    task automatic access(input int d, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] data);
        int          cycles;
        logic        got;
        logic [3:0]  idx;
        logic [31:0] exp_rd;
        idx     = a[5:2];
        en[d]   = 1'b1;
        wr[d]   = w;
        be[d]   = b;
        addr[d] = a;
        wd[d]   = data;
        cycles  = 0;
        got     = 1'b0;
        while (!got && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == 1) begin
                addr[d] = $urandom;
                wd[d]   = $urandom;
                be[d]   = 4'($urandom);
                wr[d]   = 1'($urandom);
            end
            if (rdy[d]) got = 1'b1;
        end
        check($sformatf("latency_d%0d", d), 32'(cycles), 32'(ws[d] + 1));
        en[d] = 1'b0;
        if (w) begin
            for (int k = 0; k < 4; k++)
                if (b[k]) model[d][idx][8*k +: 8] = data[8*k +: 8];
            exp_rd = last_rd[d];
        end else begin
            exp_rd     = model[d][idx];
            last_rd[d] = exp_rd;
        end
        check($sformatf("data_rd_d%0d_%s_%h", d, w ? "wr" : "rd", a), rd[d], exp_rd);
        @(posedge clk); #1;
        check($sformatf("ready_pulse_d%0d", d), {31'b0, rdy[d]}, 32'd0);
        check($sformatf("data_rd_hold_d%0d", d), rd[d], exp_rd);
    endtask

    initial begin
        int   n;
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; wr[d] = 1'b0; be[d] = '0; addr[d] = '0; wd[d] = '0;
        end
        clear_model();

        #3;
        for (int d = 0; d < 2; d++) begin
            check("reset_data_rd", rd[d], 32'd0);
            check("reset_ready", {31'b0, rdy[d]}, 32'd0);
            check("reset_init_done", {31'b0, done[d]}, 32'd0);
        end

        // Clear sequence with requests held active the whole time.
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn  = 1'b1;
        en[0] = 1'b1;
        en[1] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("clear_no_ready_c%0d", i), {31'b0, rdy[d]}, 32'd0);
                check($sformatf("clear_init_done_c%0d", i), {31'b0, done[d]}, (i == 16) ? 32'd1 : 32'd0);
            end
        end
        en[0] = 1'b0;
        en[1] = 1'b0;

        access(0, 1'b0, 4'hF, 32'h0000_0024, 32'h0);
        access(1, 1'b0, 4'hF, 32'h0000_003C, 32'h0);

        access(0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
        access(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        check("deadbeef", rd[0], 32'hDEAD_BEEF);

        access(1, 1'b1, 4'hF, 32'h0000_0020, 32'hAAAA_AAAA);
        access(1, 1'b1, 4'b0101, 32'h0000_0020, 32'h1122_3344);
        access(1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
        check("be_merge", rd[1], 32'hAA22_AA44);
        access(1, 1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF);
        access(1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        check("be_zero", rd[1], 32'hAA22_AA44);

        access(1, 1'b1, 4'hF, 32'h0000_0040, 32'h0000_0055);
        access(1, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
        check("alias", rd[1], 32'h0000_0055);

        for (int i = 0; i < 40; i++) begin
            access(int'($urandom_range(1, 0)), 1'($urandom), 4'($urandom), $urandom, $urandom);
        end

        // Reset in the middle of a waiting write.
        access(1, 1'b1, 4'hF, 32'h0000_000C, 32'h1234_5678);
        access(1, 1'b0, 4'hF, 32'h0000_000C, 32'h0);
        en[1] = 1'b1; wr[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h0000_0008; wd[1] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("midreset_data_rd", rd[d], 32'd0);
            check("midreset_ready", {31'b0, rdy[d]}, 32'd0);
            check("midreset_init_done", {31'b0, done[d]}, 32'd0);
        end
        en[1] = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        n = 0;
        while (!(done[0] && done[1]) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("reinit_done", {31'b0, done[0] & done[1]}, 32'd1);
        check("reinit_cycles", 32'(n), 32'd16);
        clear_model();
        access(1, 1'b0, 4'hF, 32'h0000_0008, 32'h0);
        check("aborted_write", rd[1], 32'd0);
        access(1, 1'b0, 4'hF, 32'h0000_000C, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_waitstate.md
# ram_waitstate

Parametrised single-port synchronous RAM for the SoC testbench and on-chip memory, generalising the basic word RAM with byte-addressed access, byte-lane write strobes, a request/ready handshake with programmable wait states, registered read data, and an optional hardware clear sequence after reset. It sits on the core's data/instruction memory bus and lets the bench model slow memories without changing the requester.

## Interface

Parameters:
- AWIDTH, 10: log2 of depth in words.
- DWIDTH, 32: word width; multiple of 8. NB = DWIDTH/8 byte lanes, OFS = log2(NB).
- WAIT_STATES, 0: extra cycles between request acceptance and response; 0..15.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset release; 0 = contents untouched by reset.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- mem_en  in  1  request valid; held by requester until mem_ready.
- mem_wr  in  1  1 = write, 0 = read.
- mem_be  in  NB  byte-lane write strobes; ignored on reads.
- addr  in  32  byte address; word index = addr[AWIDTH+OFS-1:OFS]; other bits ignored.
- data_wr  in  DWIDTH  write data.
- data_rd  out  DWIDTH  registered read data.
- mem_ready  out  1  one-cycle response strobe.
- init_done  out  1  high once memory is accepting requests.

## Operation

- States: CLEAR, IDLE, WAIT, RESP.
- Reset (async): state = CLEAR if CLEAR_ON_RESET else IDLE; clear counter, wait counter, data_rd, mem_ready, init_done all 0. Array not reset asynchronously.
- CLEAR: one word zeroed per cycle, index 0 to 2^AWIDTH-1; mem_en ignored; on last index go IDLE, init_done set to 1.
- CLEAR_ON_RESET=0: init_done goes 1 at first clock edge after rstn deasserts.
- IDLE: if mem_en=1, latch addr index, mem_wr, mem_be, data_wr; go WAIT (WAIT_STATES>0, counter loaded) or directly to access.
- WAIT: count down; at terminal count perform access.
- Access happens at the edge entering RESP: write updates only lanes with mem_be[k]=1; read loads data_rd with full word. mem_ready=1 during RESP only.
- RESP: always returns to IDLE next edge; mem_en in RESP cycle not sampled.
- data_rd holds last read value; writes do not change it.
- mem_be=0 write: no array change, response still given.
- Out-of-range upper address bits alias (wrap modulo depth).
- Inputs changing after acceptance have no effect on the in-flight access.

## Timing

- Request sampled in IDLE cycle N; mem_ready high in cycle N+1+WAIT_STATES; data_rd valid same cycle and held after.
- Back-to-back: next request accepted in IDLE cycle N+2+WAIT_STATES; peak throughput one access per WAIT_STATES+2 cycles.
- Clear takes 2^AWIDTH cycles after rstn release; init_done rises at edge ending the last clear cycle.
- Read after write to same word returns new data (write committed before next IDLE).
- Reset mid-clear restarts clear from index 0. Reset mid-access aborts: no write, mem_ready 0, data_rd 0.

## Test plan

- Reset release, AWIDTH=4, CLEAR_ON_RESET=1, mem_en held 1 -> no mem_ready for 16 cycles, init_done rises after cycle 16; read any word -> 0x00000000.
- WAIT_STATES=0: write 0xDEADBEEF to addr 0x10, then read 0x10 -> mem_ready 1 cycle after each accept; data_rd=0xDEADBEEF.
- mem_be=4'b0101, data_wr=0x11223344 over 0xAAAAAAAA -> read returns 0xAA22AA44; mem_be=0 write -> word unchanged, mem_ready still pulses.
- WAIT_STATES=3: read accepted cycle N -> mem_ready exactly at N+4, single-cycle; data_rd held until next read.
- AWIDTH=4: write 0x55 at addr 0x40 (index 0 aliased) -> read addr 0x00 returns 0x55.
- Assert rstn low during WAIT of a write -> data_rd=0, mem_ready=0, init_done=0 immediately; after clear, target word is 0.
